framebuffer_stream_receiver: RTL and testbench

// - Sink end of the Rasterix framebuffer AXI Stream. Accepts STREAM_WIDTH-bit beats, unpacks them into

---
 rtl/framebuffer_stream_receiver.sv | 175 +++++++++++++++++
 tb/tb_framebuffer_stream_receiver.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_stream_receiver.sv
// ----------------------------------------------------------------------------
// framebuffer_stream_receiver
//
// Sink end of the framebuffer AXI Stream. Each accepted STREAM_WIDTH-bit beat
// holds PPB = STREAM_WIDTH/PIXEL_WIDTH pixels (pixel 0 in the LSBs). The beat
// is unpacked into one pixel per cycle and tagged with x/y coordinates for a
// scanout writer. The beat-level tlast is checked against the frame end. On a
// mismatch the coordinates resynchronise, and completed frames are counted.
//
// Ports
//   aclk, reset                   clock and synchronous active-high reset
//   s_framebuffer_axis_*          input beat stream (tvalid/tready/tlast/tdata)
//   m_pixel_tvalid/tready/tdata   output pixel stream
//   m_pixel_x, m_pixel_y          coordinates of the presented pixel
//   m_pixel_tuser                 start of frame (x==0 && y==0)
//   m_pixel_tlast                 end of line (x==X_RESOLUTION-1)
//   tlast_error                   one-cycle pulse on tlast/frame-end mismatch
//   frame_count                   completed frames, wraps at 16 bits
// ----------------------------------------------------------------------------
module framebuffer_stream_receiver #(
  parameter int STREAM_WIDTH = 64,
  parameter int PIXEL_WIDTH  = 16,
  parameter int X_RESOLUTION = 128,
  parameter int Y_RESOLUTION = 128
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    s_framebuffer_axis_tvalid,
  output logic                    s_framebuffer_axis_tready,
  input  logic                    s_framebuffer_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_framebuffer_axis_tdata,
  output logic                    m_pixel_tvalid,
  input  logic                    m_pixel_tready,
  output logic [PIXEL_WIDTH-1:0]  m_pixel_tdata,
  output logic [15:0]             m_pixel_x,
  output logic [15:0]             m_pixel_y,
  output logic                    m_pixel_tuser,
  output logic                    m_pixel_tlast,
  output logic                    tlast_error,
  output logic [15:0]             frame_count
);

  localparam int PPB   = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int IDX_W = (PPB > 1) ? $clog2(PPB) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPB - 1);
  localparam logic [15:0]      X_LAST   = 16'(X_RESOLUTION - 1);
  localparam logic [15:0]      Y_LAST   = 16'(Y_RESOLUTION - 1);

  typedef enum logic {
    EMPTY  = 1'b0,  // no beat held
    UNPACK = 1'b1   // beat held, presenting pixel[index]
  } state_t;

  state_t state, state_next;

  logic [PPB-1:0][PIXEL_WIDTH-1:0] beat_data;
  logic                            beat_last;
  logic [IDX_W-1:0]                index;
  logic [15:0]                     x;
  logic [15:0]                     y;

  logic pixel_fire;   // pixel handshake this cycle
  logic beat_done;    // last pixel of the held beat handshakes
  logic beat_accept;  // input beat handshake this cycle
  logic s_ready;
  logic x_wrap;
  logic frame_end;

  // --------------------------------------------------------------------------
  // Next-state and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    pixel_fire  = (state == UNPACK) && m_pixel_tready;
    beat_done   = pixel_fire && (index == IDX_LAST);
    // The next beat is pulled in the cycle the last pixel leaves. This gives
    // one pixel per clock with no bubble between beats. Ready is forced low
    // while reset is held.
    s_ready     = !reset && ((state == EMPTY) || beat_done);
    beat_accept = s_framebuffer_axis_tvalid && s_ready;
    x_wrap      = (x == X_LAST);
    frame_end   = x_wrap && (y == Y_LAST);

    if (state == EMPTY) begin
      if (beat_accept) begin
        state_next = UNPACK;
      end
    end else begin
      if (beat_done) begin
        state_next = beat_accept ? UNPACK : EMPTY;
      end
    end
  end

  // NOTE: every register below is written with <= so all of them update
  // together from the same pre-edge values. A blocking = here would let a
  // later statement see an already-updated value.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the beat holding register is deliberately left out of reset. Its
  // contents are only observed while state==UNPACK, and state is reset, so
  // clearing a wide datapath register would buy nothing.
  always_ff @(posedge aclk) begin
    if (beat_accept) begin
      beat_data <= s_framebuffer_axis_tdata;
    end
  end

  // --------------------------------------------------------------------------
  // Unpack index, coordinates, frame check
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (reset) begin
      beat_last   <= 1'b0;
      index       <= '0;
      x           <= '0;
      y           <= '0;
      tlast_error <= 1'b0;
      frame_count <= '0;
    end else begin
      tlast_error <= 1'b0;

      if (beat_accept) begin
        beat_last <= s_framebuffer_axis_tlast;
        index     <= '0;
      end else if (pixel_fire) begin
        index <= index + IDX_W'(1);
      end

      if (pixel_fire) begin
        if (beat_done && beat_last && !frame_end) begin
          // The source declared a frame end early. Restart the coordinates
          // so the next beat is treated as the top-left of a new frame.
          x <= '0;
          y <= '0;
        end else if (x_wrap) begin
          x <= '0;
          y <= (y == Y_LAST) ? 16'd0 : y + 16'd1;
        end else begin
          x <= x + 16'd1;
        end
      end

      if (beat_done) begin
        if (beat_last != frame_end) begin
          tlast_error <= 1'b1;
        end
        // A missing tlast still completes the frame. The counters wrap
        // naturally, so the frame is counted anyway.
        if (frame_end) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_framebuffer_axis_tready = s_ready;
  assign m_pixel_tvalid            = (state == UNPACK);
  assign m_pixel_tdata             = beat_data[index];
  assign m_pixel_x                 = x;
  assign m_pixel_y                 = y;
  assign m_pixel_tuser             = m_pixel_tvalid && (x == 16'd0) && (y == 16'd0);
  assign m_pixel_tlast             = m_pixel_tvalid && x_wrap;

endmodule

// File: tb/tb_framebuffer_stream_receiver.sv
// ----------------------------------------------------------------------------
// tb_framebuffer_stream_receiver
//
// Bench for framebuffer_stream_receiver on an 8x4 frame with 4 pixels per
// beat. A frame-position model predicts every pixel (value, coordinates, flags
// and any tlast error after it). The stream driver records what the DUT emits.
// ----------------------------------------------------------------------------
module tb_framebuffer_stream_receiver;

  localparam int SW        = 64;
  localparam int PW        = 16;
  localparam int XR        = 8;
  localparam int YR        = 4;
  localparam int PPB       = SW / PW;
  localparam int FRAME_PIX = XR * YR;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [SW-1:0] s_tdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [PW-1:0] m_tdata;
  logic [15:0]   m_x;
  logic [15:0]   m_y;
  logic          m_tuser;
  logic          m_tlast;
  logic          tlast_error;
  logic [15:0]   frame_count;

  always #5 aclk = ~aclk;

  framebuffer_stream_receiver #(
    .STREAM_WIDTH (SW),
    .PIXEL_WIDTH  (PW),
    .X_RESOLUTION (XR),
    .Y_RESOLUTION (YR)
  ) dut (
    .aclk                      (aclk),
    .reset                     (reset),
    .s_framebuffer_axis_tvalid (s_tvalid),
    .s_framebuffer_axis_tready (s_tready),
    .s_framebuffer_axis_tlast  (s_tlast),
    .s_framebuffer_axis_tdata  (s_tdata),
    .m_pixel_tvalid            (m_tvalid),
    .m_pixel_tready            (m_tready),
    .m_pixel_tdata             (m_tdata),
    .m_pixel_x                 (m_x),
    .m_pixel_y                 (m_y),
    .m_pixel_tuser             (m_tuser),
    .m_pixel_tlast             (m_tlast),
    .tlast_error               (tlast_error),
    .frame_count               (frame_count)
  );

  typedef struct {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [PW-1:0] data;
    logic [15:0]   x;
    logic [15:0]   y;
    logic          tuser;
    logic          tlast;
    logic          srdy;
    logic          err_next;
    int            cyc;
  } pix_t;

  beat_t beats_q[$];
  pix_t  exp_q[$];
  pix_t  obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int model_pos;
  int exp_frames;
  int exp_errs;

  int stall_changes;
  int bad_sready;
  int err_pulses;
  int first_accept;
  int first_valid;
  bit timed_out;

  // --------------------------------------------------------------------------
  // Reference model. The position within the frame is a plain pixel number.
  // Each beat covers PPB consecutive positions. An early tlast jumps the
  // position back to 0. Otherwise the position wraps modulo the frame size.
  // --------------------------------------------------------------------------
  task automatic model_beats();
    for (int b = 0; b < beats_q.size(); b++) begin
      beat_t bt;
      bit    fe;
      bt = beats_q[b];
      fe = (model_pos + PPB == FRAME_PIX);
      for (int k = 0; k < PPB; k++) begin
        pix_t e;
        int   p;
        p          = model_pos + k;
        e.data     = bt.data[k*PW +: PW];
        e.x        = 16'(p % XR);
        e.y        = 16'(p / XR);
        e.tuser    = (p == 0);
        e.tlast    = ((p % XR) == XR - 1);
        e.srdy     = (k == PPB - 1);
        e.err_next = (k == PPB - 1) && (bt.last != fe);
        e.cyc      = 0;
        exp_q.push_back(e);
      end
      if (bt.last != fe) exp_errs++;
      if (fe) exp_frames++;
      if (bt.last && !fe) model_pos = 0;
      else                model_pos = (model_pos + PPB) % FRAME_PIX;
    end
  endtask

  function automatic logic [SW-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  task automatic make_beats(input int n, input int last_at, input int rand_last_pct);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = rand_beat();
      b.last = (i == last_at) || (int'($urandom_range(99)) < rand_last_pct);
      beats_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    reset      = 1'b0;
    model_pos  = 0;
    exp_frames = 0;
    exp_errs   = 0;
    exp_q.delete();
    beats_q.delete();
  endtask

  // --------------------------------------------------------------------------
  // Stream driver and recorder. It drives the inputs 1 time unit after the
  // rising edge and samples the outputs on the falling edge. rdy_mode selects
  // the sink ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  // --------------------------------------------------------------------------
  task automatic run_stream(input int rdy_mode, input int gap_pct,
                            input int stop_pixels, input int max_cycles);
    bit   prev_stall = 1'b0;
    bit   prev_hs    = 1'b0;
    bit   done       = 1'b0;
    bit   s_hs;
    bit   p_hs;
    pix_t cur;
    pix_t prv;
    pix_t tmp;
    int   need;

    obs_q.delete();
    stall_changes = 0;
    bad_sready    = 0;
    err_pulses    = 0;
    first_accept  = -1;
    first_valid   = -1;
    timed_out     = 1'b0;
    need          = (stop_pixels > 0) ? stop_pixels : beats_q.size() * PPB;
    prv           = '{default: '0};

    if (beats_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
      s_tvalid = 1'b1;
      s_tdata  = beats_q[0].data;
      s_tlast  = beats_q[0].last;
    end else begin
      s_tvalid = 1'b0;
    end
    m_tready = (rdy_mode == 2) ? 1'($urandom_range(1)) : 1'b1;

    for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
      @(negedge aclk);
      if (tlast_error) err_pulses++;
      if (prev_hs) begin
        tmp          = obs_q.pop_back();
        tmp.err_next = tlast_error;
        obs_q.push_back(tmp);
      end
      cur.data     = m_tdata;
      cur.x        = m_x;
      cur.y        = m_y;
      cur.tuser    = m_tuser;
      cur.tlast    = m_tlast;
      cur.srdy     = s_tready;
      cur.err_next = 1'b0;
      cur.cyc      = cyc;
      if (prev_stall && (cur.data !== prv.data || cur.x !== prv.x || cur.y !== prv.y ||
                         cur.tuser !== prv.tuser || cur.tlast !== prv.tlast || m_tvalid !== 1'b1))
        stall_changes++;
      if (m_tvalid && !m_tready && s_tready) bad_sready++;
      s_hs = s_tvalid && s_tready;
      p_hs = m_tvalid && m_tready;
      if (s_hs && first_accept < 0) first_accept = cyc;
      if (m_tvalid && first_valid < 0) first_valid = cyc;
      if (p_hs) obs_q.push_back(cur);
      prev_stall = m_tvalid && !m_tready;
      prv        = cur;
      prev_hs    = p_hs;

      if (stop_pixels > 0) done = p_hs && (obs_q.size() == need);
      else                 done = !p_hs && (obs_q.size() >= need);

      @(posedge aclk); #1;
      if (s_hs) void'(beats_q.pop_front());
      if (done && stop_pixels > 0) begin
        s_tvalid = 1'b0;
        m_tready = 1'b0;
      end else begin
        if (!(s_tvalid && !s_hs)) begin
          if (beats_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
            s_tvalid = 1'b1;
            s_tdata  = beats_q[0].data;
            s_tlast  = beats_q[0].last;
          end else begin
            s_tvalid = 1'b0;
          end
        end
        case (rdy_mode)
          0:       m_tready = 1'b1;
          1:       m_tready = ~m_tready;
          default: m_tready = 1'($urandom_range(1));
        endcase
      end
    end
    if (!done) timed_out = 1'b1;
    s_tvalid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(posedge aclk); #1;
    reset = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || tlast_error !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: tready=%b tvalid=%b err=%b frames=%0d, want 0 0 0 0",
               s_tready, m_tvalid, tlast_error, frame_count);
    end
    @(posedge aclk); #1;
    reset = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: tready=%b tvalid=%b, want 1 0", s_tready, m_tvalid);
    end
  endtask

  task automatic test_known_beat();
    beat_t b;
    do_reset();
    b.data = 64'h0004_0003_0002_0001;
    b.last = 1'b0;
    beats_q.push_back(b);
    model_beats();
    run_stream(0, 0, 0, 200);
    n_checks++;
    if (timed_out || obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL known_beat_count: got %0d pixels (timeout=%0b), want 4", obs_q.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i].data !== 16'(i + 1) || obs_q[i].data !== exp_q[i].data) begin
          n_fail++;
          $display("FAIL known_beat_pixel%0d: got %h, want %h", i, obs_q[i].data, 16'(i + 1));
        end
      end
    end
    n_checks++;
    if (first_valid - first_accept != 1) begin
      n_fail++;
      $display("FAIL first_pixel_latency: got %0d cycles, want 1", first_valid - first_accept);
    end
  endtask

  task automatic test_full_frame(input int rdy_mode, input string name);
    do_reset();
    make_beats(8, 7, 0);
    model_beats();
    run_stream(rdy_mode, 0, 0, 2000);
    n_checks++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d pixels (timeout=%0b), want %0d", name, obs_q.size(), timed_out, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].data !== exp_q[i].data || obs_q[i].x !== exp_q[i].x || obs_q[i].y !== exp_q[i].y ||
            obs_q[i].tuser !== exp_q[i].tuser || obs_q[i].tlast !== exp_q[i].tlast ||
            obs_q[i].srdy !== exp_q[i].srdy || obs_q[i].err_next !== exp_q[i].err_next) begin
          n_fail++;
          $display("FAIL %s_pixel%0d: got d=%h (%0d,%0d) u=%b l=%b r=%b e=%b, want d=%h (%0d,%0d) u=%b l=%b r=%b e=%b",
                   name, i, obs_q[i].data, obs_q[i].x, obs_q[i].y, obs_q[i].tuser, obs_q[i].tlast,
                   obs_q[i].srdy, obs_q[i].err_next, exp_q[i].data, exp_q[i].x, exp_q[i].y,
                   exp_q[i].tuser, exp_q[i].tlast, exp_q[i].srdy, exp_q[i].err_next);
        end
      end
      if (rdy_mode == 0) begin
        n_checks++;
        if (obs_q[obs_q.size()-1].cyc - obs_q[0].cyc != FRAME_PIX - 1) begin
          n_fail++;
          $display("FAIL %s_throughput: 32 pixels spanned %0d cycles, want %0d",
                   name, obs_q[obs_q.size()-1].cyc - obs_q[0].cyc + 1, FRAME_PIX);
        end
      end
    end
    n_checks++;
    if (frame_count !== 16'(exp_frames) || err_pulses != 0) begin
      n_fail++;
      $display("FAIL %s_frame: frames=%0d errs=%0d, want frames=%0d errs=0", name, frame_count, err_pulses, exp_frames);
    end
    n_checks++;
    if (stall_changes != 0 || bad_sready != 0) begin
      n_fail++;
      $display("FAIL %s_stall: changes=%0d early_tready=%0d, want 0 0", name, stall_changes, bad_sready);
    end
  endtask

  // Shared body for the tlast mismatch scenarios and the random run.
  task automatic test_mismatch(input int n_beats, input int last_at, input int rand_last_pct,
                               input int rdy_mode, input int gap_pct, input string name);
    do_reset();
    make_beats(n_beats, last_at, rand_last_pct);
    model_beats();
    run_stream(rdy_mode, gap_pct, 0, 20000);
    n_checks++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d pixels (timeout=%0b), want %0d", name, obs_q.size(), timed_out, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].data !== exp_q[i].data || obs_q[i].x !== exp_q[i].x || obs_q[i].y !== exp_q[i].y ||
            obs_q[i].tuser !== exp_q[i].tuser || obs_q[i].tlast !== exp_q[i].tlast ||
            obs_q[i].srdy !== exp_q[i].srdy || obs_q[i].err_next !== exp_q[i].err_next) begin
          n_fail++;
          $display("FAIL %s_pixel%0d: got d=%h (%0d,%0d) u=%b l=%b r=%b e=%b, want d=%h (%0d,%0d) u=%b l=%b r=%b e=%b",
                   name, i, obs_q[i].data, obs_q[i].x, obs_q[i].y, obs_q[i].tuser, obs_q[i].tlast,
                   obs_q[i].srdy, obs_q[i].err_next, exp_q[i].data, exp_q[i].x, exp_q[i].y,
                   exp_q[i].tuser, exp_q[i].tlast, exp_q[i].srdy, exp_q[i].err_next);
        end
      end
    end
    n_checks++;
    if (frame_count !== 16'(exp_frames) || err_pulses != exp_errs) begin
      n_fail++;
      $display("FAIL %s_frame: frames=%0d errs=%0d, want frames=%0d errs=%0d",
               name, frame_count, err_pulses, exp_frames, exp_errs);
    end
    n_checks++;
    if (stall_changes != 0 || bad_sready != 0) begin
      n_fail++;
      $display("FAIL %s_stall: changes=%0d early_tready=%0d, want 0 0", name, stall_changes, bad_sready);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    make_beats(11, 7, 0);
    run_stream(0, 0, FRAME_PIX + 10, 500);
    @(negedge aclk);
    n_checks++;
    if (timed_out || m_tvalid !== 1'b1 || m_x !== 16'd2 || m_y !== 16'd1 || frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_frame_position: timeout=%0b valid=%b (%0d,%0d) frames=%0d, want 0 1 (2,1) 1",
               timed_out, m_tvalid, m_x, m_y, frame_count);
    end
    @(posedge aclk); #1;
    reset = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_tready: got %b, want 0", s_tready);
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    n_checks++;
    if (m_tvalid !== 1'b0 || frame_count !== 16'd0 || tlast_error !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: valid=%b frames=%0d err=%b, want 0 0 0", m_tvalid, frame_count, tlast_error);
    end
    @(posedge aclk); #1;
    reset      = 1'b0;
    model_pos  = 0;
    exp_frames = 0;
    exp_errs   = 0;
    exp_q.delete();
    beats_q.delete();
    make_beats(2, -1, 0);
    model_beats();
    run_stream(0, 0, 0, 200);
    n_checks++;
    if (timed_out || obs_q.size() != 8 || obs_q[0].x !== 16'd0 || obs_q[0].y !== 16'd0 ||
        obs_q[0].tuser !== 1'b1 || obs_q[0].data !== exp_q[0].data || err_pulses != 0) begin
      n_fail++;
      $display("FAIL mid_reset_restart: n=%0d first=(%0d,%0d) u=%b d=%h errs=%0d, want n=8 (0,0) u=1 d=%h errs=0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].x : 16'hFFFF,
               (obs_q.size() > 0) ? obs_q[0].y : 16'hFFFF,
               (obs_q.size() > 0) ? obs_q[0].tuser : 1'bx,
               (obs_q.size() > 0) ? obs_q[0].data : 16'hxxxx, err_pulses, exp_q[0].data);
    end
  endtask

  initial begin
    test_reset();
    test_known_beat();
    test_full_frame(0, "full_frame");
    test_full_frame(1, "backpressure");
    // tlast on beat 3 (index 2), then two more beats restarting at (0,0).
    test_mismatch(5, 2, 0, 0, 0, "early_tlast");
    // 8 beats without tlast and one more that must start the next frame.
    test_mismatch(9, -1, 0, 0, 0, "missing_tlast");
    test_mismatch(40, 7, 6, 2, 25, "random");
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
